// File: rtl/vram_pkg.sv
// Shared types and defaults for the VRAM arbiter: FSM states, grant encoding
// and the default RAM geometry.
package vram_pkg;

    localparam int AW_DEF = 15;
    localparam int DW_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RETURN = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        G_VID = 2'd0,
        G_CPU = 2'd1,
        G_BM  = 2'd2
    } grant_e;

    // Which of the two round-robin ports was served most recently.
    typedef enum logic {
        LG_CPU = 1'b0,
        LG_BM  = 1'b1
    } last_grant_e;

endpackage : vram_pkg

// File: rtl/vram_arbiter_if.sv
// Bundle of the video, CPU, bit-mode writer and RAM signals around the arbiter.
// The arbiter uses the slave view; requesters and the RAM sit on the master view.
interface vram_arbiter_if
    import vram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);

    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;
    logic          vid_valid;
    logic          vid_overrun;

    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;

    logic          bm_req;
    logic          bm_we;
    logic [AW-1:0] bm_addr;
    logic [DW-1:0] bm_wdata;
    logic [DW-1:0] bm_rdata;
    logic          bm_ack;

    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata;

    modport slave (
        input  vid_req, vid_addr,
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  bm_req, bm_we, bm_addr, bm_wdata,
        input  ram_rdata,
        output vid_data, vid_valid, vid_overrun,
        output cpu_rdata, cpu_ack,
        output bm_rdata, bm_ack,
        output ram_addr, ram_we, ram_wdata
    );

    modport master (
        output vid_req, vid_addr,
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output bm_req, bm_we, bm_addr, bm_wdata,
        output ram_rdata,
        input  vid_data, vid_valid, vid_overrun,
        input  cpu_rdata, cpu_ack,
        input  bm_rdata, bm_ack,
        input  ram_addr, ram_we, ram_wdata
    );

endinterface : vram_arbiter_if

// File: rtl/vram_prio.sv
// Grant decision: pending video fetch always wins, otherwise CPU and bit-mode
// writer alternate when both are asking. Purely combinational.
module vram_prio
    import vram_pkg::*;
(
    input  logic        vid_pend,
    input  logic        cpu_req,
    input  logic        bm_req,
    input  last_grant_e last_grant,
    output grant_e      grant
);

    // NOTE: every output gets a default before any branch so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        grant = G_VID;
        if (vid_pend) begin
            grant = G_VID;
        end else if (cpu_req && bm_req) begin
            grant = (last_grant == LG_BM) ? G_CPU : G_BM;
        end else if (cpu_req) begin
            grant = G_CPU;
        end else if (bm_req) begin
            grant = G_BM;
        end
    end

endmodule : vram_prio

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: video fetch, CPU and bit-mode writer share one
// synchronous RAM, one access every two cycles (ACCESS then RETURN).
module vram_arbiter
    import vram_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
)
(
    input  logic           clk,
    input  logic           reset_n,
    vram_arbiter_if.slave  bus
);

    state_e        state_q, state_d;
    grant_e        cur_q;
    grant_e        grant_w;
    last_grant_e   last_grant_q;
    logic          rst_done_q;

    logic          vid_pend_q;
    logic [AW-1:0] vid_pend_addr_q;
    logic          vid_overrun_q;

    logic [AW-1:0] ram_addr_q;
    logic [DW-1:0] ram_wdata_q;
    logic          ram_we_q;

    logic [DW-1:0] vid_data_q;
    logic [DW-1:0] cpu_rdata_q;
    logic [DW-1:0] bm_rdata_q;

    logic          in_return;
    logic          vid_done, cpu_done, bm_done;
    logic          vid_want, cpu_want, bm_want;
    logic          arb_slot, grant_now;

    logic [AW-1:0] acc_addr;
    logic [DW-1:0] acc_wdata;
    logic          acc_we;

    // ------------------------------------------------------------------
    // Arbitration inputs. The port finishing in RETURN is masked so a
    // requester still holding req during its ack cycle is not re-granted
    // for the same transaction; a fresh vid_req competes in its own cycle.
    // ------------------------------------------------------------------
    assign in_return = (state_q == RETURN);
    assign vid_done  = in_return && (cur_q == G_VID);
    assign cpu_done  = in_return && (cur_q == G_CPU);
    assign bm_done   = in_return && (cur_q == G_BM);

    assign vid_want  = bus.vid_req | (vid_pend_q & ~vid_done);
    assign cpu_want  = bus.cpu_req & ~cpu_done;
    assign bm_want   = bus.bm_req  & ~bm_done;

    // rst_done_q holds off the first grant by one edge after reset release.
    assign arb_slot  = rst_done_q && ((state_q == IDLE) || in_return);
    assign grant_now = arb_slot && (vid_want || cpu_want || bm_want);

    vram_prio u_prio (
        .vid_pend   (vid_want),
        .cpu_req    (cpu_want),
        .bm_req     (bm_want),
        .last_grant (last_grant_q),
        .grant      (grant_w)
    );

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (grant_now) state_d = ACCESS;
            ACCESS:  state_d = RETURN;
            RETURN:  state_d = grant_now ? ACCESS : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Winning port's access fields; video never writes and keeps the old wdata.
    always_comb begin
        acc_addr  = ram_addr_q;
        acc_wdata = ram_wdata_q;
        acc_we    = 1'b0;
        unique case (grant_w)
            G_VID: acc_addr = bus.vid_req ? bus.vid_addr : vid_pend_addr_q;
            G_CPU: begin
                acc_addr  = bus.cpu_addr;
                acc_wdata = bus.cpu_wdata;
                acc_we    = bus.cpu_we;
            end
            G_BM: begin
                acc_addr  = bus.bm_addr;
                acc_wdata = bus.bm_wdata;
                acc_we    = bus.bm_we;
            end
            default: ;
        endcase
    end

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            rst_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_done_q <= 1'b1;
        end
    end

    // RAM drive registers: loaded at the grant edge, so they are valid for
    // exactly the ACCESS cycle; address and data then hold.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur_q        <= G_VID;
            last_grant_q <= LG_BM;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            ram_we_q     <= 1'b0;
        end else if (grant_now) begin
            cur_q       <= grant_w;
            ram_addr_q  <= acc_addr;
            ram_wdata_q <= acc_wdata;
            ram_we_q    <= acc_we;
            if (grant_w != G_VID) begin
                last_grant_q <= (grant_w == G_BM) ? LG_BM : LG_CPU;
            end
        end else begin
            ram_we_q <= 1'b0;
        end
    end

    // Video pending slot. A new pulse on the cycle the old fetch returns just
    // re-arms the slot; any other pulse while pending is an overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vid_pend_q      <= 1'b0;
            vid_pend_addr_q <= '0;
            vid_overrun_q   <= 1'b0;
        end else if (bus.vid_req) begin
            vid_pend_q      <= 1'b1;
            vid_pend_addr_q <= bus.vid_addr;
            if (vid_pend_q && !vid_done) begin
                vid_overrun_q <= 1'b1;
            end
        end else if (vid_done) begin
            vid_pend_q <= 1'b0;
        end
    end

    // Read-data holding registers for the cycles between strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vid_data_q  <= '0;
            cpu_rdata_q <= '0;
            bm_rdata_q  <= '0;
        end else begin
            if (vid_done) vid_data_q  <= bus.ram_rdata;
            if (cpu_done) cpu_rdata_q <= bus.ram_rdata;
            if (bm_done)  bm_rdata_q  <= bus.ram_rdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: RETURN passes ram_rdata straight through so data and strobe
    // appear two cycles after the grant.
    // ------------------------------------------------------------------
    assign bus.vid_valid   = vid_done;
    assign bus.vid_data    = vid_done ? bus.ram_rdata : vid_data_q;
    assign bus.vid_overrun = vid_overrun_q;

    assign bus.cpu_ack     = cpu_done;
    assign bus.cpu_rdata   = cpu_done ? bus.ram_rdata : cpu_rdata_q;

    assign bus.bm_ack      = bm_done;
    assign bus.bm_rdata    = bm_done ? bus.ram_rdata : bm_rdata_q;

    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_wdata   = ram_wdata_q;
    assign bus.ram_we      = ram_we_q;

endmodule : vram_arbiter

// File: tb/tb_vram_arbiter.sv
// Scoreboard bench for vram_arbiter: write-first RAM model, expected data queued
// per port at request time and popped on each ack/valid strobe.
module tb_vram_arbiter;
    import vram_pkg::*;

    localparam int AW = AW_DEF;
    localparam int DW = DW_DEF;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    vram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

    vram_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Initial RAM image; 0x1234 preloaded with 0xA5.
    function automatic logic [DW-1:0] init_val(input int a);
        return (a == 32'h1234) ? 8'hA5 : DW'(a * 13 + 7);
    endfunction

    logic [DW-1:0] ram [int];
    logic [DW-1:0] ref_mem [int];

    function automatic logic [DW-1:0] ram_rd(input int a);
        return ram.exists(a) ? ram[a] : init_val(a);
    endfunction

    function automatic logic [DW-1:0] model_rd(input int a);
        return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
    endfunction

    // Synchronous single-port RAM, read latency 1, write-first.
    always @(posedge clk) begin : ram_model
        logic [DW-1:0] rd;
        int a;
        a  = int'(bus.ram_addr);
        rd = ram_rd(a);
        if (bus.ram_we) begin
            ram[a] = bus.ram_wdata;
            rd     = bus.ram_wdata;
        end
        bus.ram_rdata <= rd;
    end

    // Scoreboard queues and strobe log (port 0 video, 1 CPU, 2 BM).
    typedef struct { int port; int cyc; } ev_t;
    logic [DW-1:0] vid_q[$];
    logic [DW-1:0] cpu_q[$];
    logic [DW-1:0] bm_q[$];
    ev_t           ev_log[$];

    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.vid_valid) begin
                ev_log.push_back('{port: 0, cyc: cyc});
                if (vid_q.size() == 0) check("vid_unexpected", 1, 0);
                else check("vid_data", bus.vid_data, vid_q.pop_front());
            end
            if (bus.cpu_ack) begin
                ev_log.push_back('{port: 1, cyc: cyc});
                if (cpu_q.size() == 0) check("cpu_unexpected", 1, 0);
                else check("cpu_rdata", bus.cpu_rdata, cpu_q.pop_front());
            end
            if (bus.bm_ack) begin
                ev_log.push_back('{port: 2, cyc: cyc});
                if (bm_q.size() == 0) check("bm_unexpected", 1, 0);
                else check("bm_rdata", bus.bm_rdata, bm_q.pop_front());
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        check({tag, "_ctl"}, {bus.cpu_ack, bus.bm_ack, bus.vid_valid, bus.vid_overrun, bus.ram_we}, 0);
        check({tag, "_data"}, {bus.ram_addr, bus.ram_wdata, bus.vid_data, bus.cpu_rdata, bus.bm_rdata}, 0);
    endtask

    task automatic idle_inputs();
        bus.vid_req = 0; bus.vid_addr = '0;
        bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.bm_req  = 0; bus.bm_we  = 0; bus.bm_addr  = '0; bus.bm_wdata  = '0;
    endtask

    task automatic do_reset();
        reset_n = 0;
        idle_inputs();
        vid_q.delete(); cpu_q.delete(); bm_q.delete();
        @(negedge clk);
        check_zero_outputs("reset");
        @(posedge clk); #1 reset_n = 1;
        repeat (2) @(posedge clk);
        #1;
        ev_log.delete();
    endtask

    // One CPU (port 1) or BM (port 2) transaction; keep leaves req high
    // so the next call chains without a gap.
    task automatic txn(input int port, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input bit keep);
        logic [DW-1:0] exp;
        bit acked;
        exp = we ? wdata : model_rd(int'(addr));
        if (we) ref_mem[int'(addr)] = wdata;
        if (port == 1) begin
            cpu_q.push_back(exp);
            bus.cpu_we = we; bus.cpu_addr = addr; bus.cpu_wdata = wdata; bus.cpu_req = 1;
        end else begin
            bm_q.push_back(exp);
            bus.bm_we = we; bus.bm_addr = addr; bus.bm_wdata = wdata; bus.bm_req = 1;
        end
        acked = 0;
        for (int n = 0; n < 32 && !acked; n++) begin
            @(negedge clk);
            acked = (port == 1) ? bus.cpu_ack : bus.bm_ack;
        end
        if (!acked) check(port == 1 ? "cpu_ack_timeout" : "bm_ack_timeout", 0, 1);
        @(posedge clk); #1;
        if (!keep) begin
            if (port == 1) bus.cpu_req = 0;
            else bus.bm_req = 0;
        end
    endtask

    task automatic vid_pulse(input logic [AW-1:0] addr, input bit expect_data);
        if (expect_data) vid_q.push_back(model_rd(int'(addr)));
        bus.vid_addr = addr;
        bus.vid_req  = 1;
        @(posedge clk); #1;
        bus.vid_req  = 0;
    endtask

    task automatic check_event(input int idx, input int port, input int at);
        check($sformatf("ev%0d_port", idx), ev_log[idx].port, port);
        check($sformatf("ev%0d_cyc", idx), ev_log[idx].cyc, at);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        bit acked;
        idle_inputs();

        // Single CPU read of a preloaded location.
        do_reset();
        t0 = cyc;
        fork
            txn(1, 1'b0, 15'h1234, 8'h00, 1'b0);
            begin
                @(negedge clk);
                @(negedge clk);
                check("rd_ram_addr", bus.ram_addr, 15'h1234);
                check("rd_ram_we", bus.ram_we, 0);
                @(negedge clk);
                check("rd_ack", bus.cpu_ack, 1);
                check("rd_data", bus.cpu_rdata, 8'hA5);
            end
        join
        @(negedge clk);
        check("rd_ack_pulse", bus.cpu_ack, 0);
        check("rd_data_hold", bus.cpu_rdata, 8'hA5);

        // Three-way contention: video, then CPU, then BM back to back.
        do_reset();
        t0 = cyc;
        fork
            vid_pulse(15'h0100, 1'b1);
            txn(1, 1'b0, 15'h0200, 8'h00, 1'b0);
            txn(2, 1'b0, 15'h0300, 8'h00, 1'b0);
        join
        repeat (2) @(posedge clk);
        check("cont_events", ev_log.size(), 3);
        if (ev_log.size() == 3) begin
            check_event(0, 0, t0 + 2);
            check_event(1, 1, t0 + 4);
            check_event(2, 2, t0 + 6);
        end

        // Round-robin: continuous CPU and BM writes alternate, CPU first.
        do_reset();
        t0 = cyc;
        fork
            for (int i = 0; i < 4; i++) txn(1, 1'b1, AW'(15'h2000 + i), DW'(8'h10 + i), i < 3);
            for (int i = 0; i < 4; i++) txn(2, 1'b1, AW'(15'h3000 + i), DW'(8'h80 + i), i < 3);
        join
        repeat (2) @(posedge clk);
        check("rr_events", ev_log.size(), 8);
        if (ev_log.size() == 8) begin
            for (int i = 0; i < 8; i++) check_event(i, (i % 2 == 0) ? 1 : 2, t0 + 2 + 2 * i);
        end
        for (int i = 0; i < 4; i++) begin
            check($sformatf("rr_mem_cpu%0d", i), ram_rd(32'h2000 + i), 8'h10 + i);
            check($sformatf("rr_mem_bm%0d", i), ram_rd(32'h3000 + i), 8'h80 + i);
        end

        // Video re-request on the cycle its fetch returns: refetch, no overrun.
        do_reset();
        t0 = cyc;
        fork
            vid_pulse(15'h0C00, 1'b1);
            begin
                @(posedge clk); #1;
                @(posedge clk); #1;
                vid_pulse(15'h0D00, 1'b1);
            end
        join
        repeat (4) @(posedge clk);
        check("rearm_events", ev_log.size(), 2);
        if (ev_log.size() == 2) begin
            check_event(0, 0, t0 + 2);
            check_event(1, 0, t0 + 4);
        end
        check("rearm_overrun", bus.vid_overrun, 0);

        // Overrun: two pulses while the CPU access is in flight.
        do_reset();
        t0 = cyc;
        fork
            txn(1, 1'b0, 15'h0500, 8'h00, 1'b0);
            begin
                @(posedge clk); #1;
                vid_pulse(15'h0A00, 1'b0);
                vid_pulse(15'h0B00, 1'b1);
            end
        join
        repeat (4) @(posedge clk);
        #1;
        check("ovr_flag", bus.vid_overrun, 1);
        check("ovr_events", ev_log.size(), 2);
        if (ev_log.size() == 2) begin
            check_event(0, 1, t0 + 2);
            check_event(1, 0, t0 + 4);
        end
        vid_pulse(15'h0E00, 1'b1);
        repeat (4) @(posedge clk);
        check("ovr_sticky", bus.vid_overrun, 1);
        check("ovr_events2", ev_log.size(), 3);

        // Reset during ACCESS of a CPU write to the top address.
        do_reset();
        bus.cpu_we = 1; bus.cpu_addr = 15'h7FFF; bus.cpu_wdata = 8'h5A; bus.cpu_req = 1;
        @(posedge clk); #1;
        reset_n = 0;
        @(negedge clk);
        check_zero_outputs("midrst");
        @(posedge clk); #1;
        check("midrst_no_write", ram_rd(32'h7FFF), init_val(32'h7FFF));
        cpu_q.push_back(8'h5A);
        ref_mem[32'h7FFF] = 8'h5A;
        reset_n = 1;
        @(negedge clk);
        check("midrst_hold0", bus.ram_we, 0);
        @(negedge clk);
        check("midrst_hold1", bus.ram_we, 0);
        @(negedge clk);
        check("midrst_retry_we", bus.ram_we, 1);
        check("midrst_retry_addr", bus.ram_addr, 15'h7FFF);
        acked = 0;
        for (int n = 0; n < 8 && !acked; n++) begin
            @(negedge clk);
            acked = bus.cpu_ack;
        end
        check("midrst_ack", acked, 1);
        @(posedge clk); #1;
        bus.cpu_req = 0;
        repeat (2) @(posedge clk);
        check("midrst_mem", ram_rd(32'h7FFF), 8'h5A);

        check("vid_q_empty", vid_q.size(), 0);
        check("cpu_q_empty", cpu_q.size(), 0);
        check("bm_q_empty", bm_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_vram_arbiter

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter AW, default 15, SHALL set the bitmap RAM address width.
REQ-002 Parameter DW, default 8, SHALL set the RAM data width.
REQ-003 Clock and reset SHALL be: clk in 1, single clock for all logic; reset_n in 1, asynchronous, active-low.
REQ-004 Video port SHALL be:
  - vid_req in 1: one-cycle fetch pulse.
  - vid_addr in AW.
  - vid_data out DW.
  - vid_valid out 1: one-cycle data strobe.
  - vid_overrun out 1: sticky error flag.
REQ-005 CPU port SHALL be:
  - cpu_req in 1: level, held until ack.
  - cpu_we in 1.
  - cpu_addr in AW.
  - cpu_wdata in DW.
  - cpu_rdata out DW.
  - cpu_ack out 1: one-cycle.
REQ-006 Bit-mode writer port SHALL be:
  - bm_req in 1.
  - bm_we in 1.
  - bm_addr in AW.
  - bm_wdata in DW.
  - bm_rdata out DW.
  - bm_ack out 1: same semantics as the CPU port.
REQ-007 RAM port SHALL be:
  - ram_addr out AW.
  - ram_we out 1.
  - ram_wdata out DW.
  - ram_rdata in DW: synchronous single-port RAM, read latency 1.

Function
REQ-008 The FSM SHALL have three states:
  - IDLE: no access.
  - ACCESS: drive the RAM for one cycle.
  - RETURN: capture ram_rdata and ack.
REQ-009 A vid_req pulse SHALL latch vid_addr into vid_pend_addr and set vid_pend.
REQ-010 Arbitration SHALL run in IDLE and RETURN only. The priority SHALL be vid_pend first, then CPU/BM round-robin.
REQ-011 Round-robin SHALL use a last_grant bit:
  - When both CPU and BM request, the port not granted last wins.
  - last_grant updates only on a CPU or BM grant.
REQ-012 When granted, ACCESS SHALL drive ram_addr, ram_we and ram_wdata from the winning port. ram_we SHALL be forced 0 for video.
REQ-013 In RETURN:
  - Video: vid_data = ram_rdata, vid_valid = 1 for one cycle, vid_pend cleared.
  - CPU/BM: rdata = ram_rdata, ack = 1 for one cycle. Writes are acked identically, and rdata then holds the RAM's read-during-write value.
REQ-014 Latency from grant SHALL be 2 cycles: ACCESS, then RETURN carrying ack/valid. If a request is pending in RETURN, the next ACCESS SHALL follow immediately, giving one access per 2 cycles.
REQ-015 With no request pending in RETURN, the next state SHALL be IDLE. From IDLE with no request, the FSM SHALL stay in IDLE.
REQ-016 Outside ACCESS, ram_we SHALL be 0. ram_addr and ram_wdata SHALL hold their last values.
REQ-017 A vid_req arriving while vid_pend=1 and not being cleared that cycle SHALL:
  - set vid_overrun, which stays set until reset;
  - replace vid_pend_addr with the new address.
REQ-018 A vid_req in the same cycle that vid_pend clears (RETURN of video) SHALL set vid_pend again with the new address and SHALL NOT flag overrun.
REQ-019 A CPU/BM requester deasserting req before ack is a protocol violation. The arbiter SHALL still complete an access already in ACCESS and SHALL pulse its ack.
REQ-020 Worst-case CPU/BM wait SHALL be bounded at 6 cycles from req to ACCESS, given vid_req spacing of at least 4 cycles.
REQ-021 cpu_rdata and bm_rdata SHALL hold between acks.

Reset
REQ-022 While reset_n=0:
  - FSM = IDLE; vid_pend = 0; vid_overrun = 0; last_grant = BM, so the CPU wins the first tie.
  - All acks, vid_valid and ram_we = 0.
  - ram_addr, ram_wdata, vid_data, cpu_rdata and bm_rdata = 0.
REQ-023 Reset asserted mid-access SHALL abort it with no ack or valid issued. The first grant after release SHALL NOT occur before the second rising clk edge.

Structure
REQ-024 A shared package vram_pkg SHALL hold:
  - the state enum (IDLE, ACCESS, RETURN);
  - the grant enum (G_VID, G_CPU, G_BM);
  - constants AW_DEF = 15 and DW_DEF = 8.
REQ-025 The round-robin/priority decision SHALL be one combinational sub-module, vram_prio, with inputs vid_pend, cpu_req, bm_req, last_grant and output grant. Everything else stays in vram_arbiter.

Verification
REQ-026 Single CPU read: cpu_req=1, cpu_addr=0x1234, RAM holds 0xA5 at that address -> ram_addr=0x1234 on cycle+1, cpu_ack=1 and cpu_rdata=0xA5 on cycle+2.
REQ-027 Contention: vid_req pulse (addr 0x0100) with cpu_req and bm_req held -> grant order video, CPU, BM at ACCESS cycles 1, 3, 5, with no idle gap.
REQ-028 Round-robin: CPU and BM both requesting writes continuously for 8 accesses -> strict alternation, starting with CPU after reset; the RAM contents are verified afterwards.
REQ-029 Overrun: vid_req at cycle 0 and again at cycle 1 while CPU is in ACCESS -> vid_overrun=1 and remains 1; the fetch returns data for the second address only.
REQ-030 Reset mid-access: reset_n low during ACCESS of a CPU write to 0x7FFF -> no cpu_ack, all outputs 0; after release the CPU write retries and acks normally.
